// File: rtl/uart_rx_oversampled.sv
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_oversampled                                          |
// | Description : Oversampled UART receiver with one-entry valid/ready output  |
// |               holding register, framing-error and overrun pulses.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_rx_oversampled #(
    parameter int DBIT = 8,
    parameter int OS   = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            frame_err,
    output logic            overrun,
    output logic            busy
);

    localparam int c_SW = (OS > 1) ? $clog2(OS) : 1;
    localparam int c_NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [c_SW-1:0] c_MID   = c_SW'(OS / 2 - 1);
    localparam logic [c_SW-1:0] c_LAST  = c_SW'(OS - 1);
    localparam logic [c_SW-1:0] c_S_ONE = c_SW'(1);
    localparam logic [c_NW-1:0] c_NLAST = c_NW'(DBIT - 1);
    localparam logic [c_NW-1:0] c_N_ONE = c_NW'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic            r_rx_meta;
    logic            r_rx_s;
    logic [1:0]      r_state;
    logic [c_SW-1:0] r_s;
    logic [c_NW-1:0] r_n;
    logic [DBIT-1:0] r_shift;

    logic [1:0]      w_state_nxt;
    logic [c_SW-1:0] w_s_nxt;
    logic [c_NW-1:0] w_n_nxt;
    logic [DBIT-1:0] w_shift_nxt;
    logic            w_good;
    logic            w_ferr;
    logic            w_load;
    logic            w_drop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = r_s;
        w_n_nxt     = r_n;
        w_shift_nxt = r_shift;
        w_good      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            c_IDLE: begin
                // Leaving IDLE is edge driven, not tick driven, to keep start-edge latency minimal
                if (!r_rx_s) begin
                    w_state_nxt = c_START;
                    w_s_nxt     = '0;
                end
            end
            c_START: begin
                if (s_tick) begin
                    if (r_s == c_MID) begin
                        w_s_nxt = '0;
                        w_n_nxt = '0;
                        w_state_nxt = r_rx_s ? c_IDLE : c_DATA;
                    end else begin
                        w_s_nxt = r_s + c_S_ONE;
                    end
                end
            end
            c_DATA: begin
                if (s_tick) begin
                    if (r_s == c_LAST) begin
                        w_s_nxt     = '0;
                        w_shift_nxt = {r_rx_s, r_shift[DBIT-1:1]};
                        if (r_n == c_NLAST) begin
                            w_state_nxt = c_STOP;
                        end else begin
                            w_n_nxt = r_n + c_N_ONE;
                        end
                    end else begin
                        w_s_nxt = r_s + c_S_ONE;
                    end
                end
            end
            c_STOP: begin
                if (s_tick) begin
                    if (r_s == c_LAST) begin
                        w_state_nxt = c_IDLE;
                        w_s_nxt     = '0;
                        w_good      = r_rx_s;
                        w_ferr      = !r_rx_s;
                    end else begin
                        w_s_nxt = r_s + c_S_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_s_nxt     = '0;
                w_n_nxt     = '0;
            end
        endcase
    end

    always_comb begin
        busy   = (r_state != c_IDLE);
        // A consume in the load clk frees the slot, so the new byte wins
        w_load = w_good && (!rx_valid || rx_ready);
        w_drop = w_good && rx_valid && !rx_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_load) begin
                rx_data  <= r_shift;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            frame_err <= w_ferr;
            overrun   <= w_drop;
        end
    end

endmodule

`default_nettype wire
